// File: rtl/sha256_round_ctrl.sv
// ---------------------------------------------------------------------------
// sha256_round_ctrl
//   Sequencer for one SHA-256 compression.
//   - Accepts a 512-bit block from the source.
//   - Drives the round datapath for ROUNDS cycles.
//   - Supplies the K-ROM index and W_t each round from a 16-word
//     message-schedule window.
//   - Strobes the final hash add.
//   - Holds digest_valid until the consumer takes the digest.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   blk_valid/ready   block handshake from the source
//   blk_data          512-bit block, word 0 = blk_data[511:480]
//   blk_first         sampled with the block: 1 = start from IV, 0 = chain
//   abort             synchronous cancel of the block in flight
//   ld_state, ld_iv   one-cycle load of a..h (from IV when ld_iv)
//   round_en          datapath executes a round this cycle
//   k_addr, w_t       K-ROM index and schedule word for the current round
//   final_add         one-cycle H_i <= H_i + working variable
//   digest_valid/rdy  digest handshake to the consumer
//   busy              controller is not idle
// ---------------------------------------------------------------------------
module sha256_round_ctrl #(
    parameter int ROUNDS = 64,
    parameter int BLK_W  = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [BLK_W-1:0] blk_data,
    input  logic             blk_first,
    input  logic             abort,
    output logic             ld_state,
    output logic             ld_iv,
    output logic             round_en,
    output logic [5:0]       k_addr,
    output logic [31:0]      w_t,
    output logic             final_add,
    output logic             digest_valid,
    input  logic             digest_ready,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [5:0]  t_reg, t_next;
    logic        first_reg;
    logic [31:0] window_reg  [16];
    logic [31:0] window_next [16];
    logic [31:0] w_new;
    logic        accept;
    logic        last_round;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    assign accept     = (state_reg == S_IDLE) && blk_valid;
    assign last_round = (t_reg == 6'(ROUNDS - 1));

    // Window holds W[t..t+15].
    // The word entering at the top is W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t].
    assign w_new = sig1(window_reg[14]) + window_reg[9] + sig0(window_reg[1]) + window_reg[0];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_window
            if (gi < 15) begin : g_shift
                assign window_next[gi] = accept                  ? blk_data[BLK_W-1-32*gi -: 32] :
                                         (state_reg == S_ROUND)  ? window_reg[gi+1] :
                                                                   window_reg[gi];
            end else begin : g_top
                assign window_next[gi] = accept                  ? blk_data[BLK_W-1-32*gi -: 32] :
                                         (state_reg == S_ROUND)  ? w_new :
                                                                   window_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            t_reg     <= 6'd0;
            first_reg <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                window_reg[i] <= 32'd0;
            end
        end else begin
            state_reg  <= state_next;
            t_reg      <= t_next;
            window_reg <= window_next;
            if (accept) begin
                first_reg <= blk_first;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        t_next       = t_reg;
        blk_ready    = 1'b0;
        ld_state     = 1'b0;
        ld_iv        = 1'b0;
        round_en     = 1'b0;
        final_add    = 1'b0;
        digest_valid = 1'b0;

        case (state_reg)
            S_IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    state_next = S_LOAD;
                    t_next     = 6'd0;
                end
            end
            S_LOAD: begin
                ld_state   = 1'b1;
                ld_iv      = first_reg;
                state_next = S_ROUND;
            end
            S_ROUND: begin
                round_en = 1'b1;
                if (last_round) begin
                    state_next = S_FINAL;
                    t_next     = 6'd0;
                end else begin
                    t_next = t_reg + 6'd1;
                end
            end
            S_FINAL: begin
                // An abort landing on this cycle must cancel the hash update.
                final_add  = !abort;
                state_next = S_DONE;
            end
            S_DONE: begin
                digest_valid = !abort;
                if (digest_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                t_next     = 6'd0;
            end
        endcase

        // Abort wins over every other transition once a block is in flight.
        if (abort && (state_reg != S_IDLE)) begin
            state_next = S_IDLE;
            t_next     = 6'd0;
        end
    end

    assign k_addr = t_reg;
    assign w_t    = window_reg[0];
    assign busy   = (state_reg != S_IDLE);

endmodule

// File: tb/tb_sha256_round_ctrl.sv
module tb_sha256_round_ctrl;

    localparam int ROUNDS = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         abort;
    logic         ld_state;
    logic         ld_iv;
    logic         round_en;
    logic [5:0]   k_addr;
    logic [31:0]  w_t;
    logic         final_add;
    logic         digest_valid;
    logic         digest_ready;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;
    int blk_no   = 0;

    logic [31:0] wexp [64];

    sha256_round_ctrl #(.ROUNDS(ROUNDS), .BLK_W(512)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .blk_data     (blk_data),
        .blk_first    (blk_first),
        .abort        (abort),
        .ld_state     (ld_state),
        .ld_iv        (ld_iv),
        .round_en     (round_en),
        .k_addr       (k_addr),
        .w_t          (w_t),
        .final_add    (final_add),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Strobe exclusivity and X-freedom on every cycle of every scenario.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("strobe_excl", 64'($countones({ld_state, round_en, final_add}) <= 1), 64'd1);
            chk("no_x", 64'($isunknown({blk_ready, ld_state, ld_iv, round_en, k_addr,
                                         w_t, final_add, digest_valid, busy})), 64'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Textbook SHA-256 message expansion.
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic build_w(input logic [511:0] d);
        for (int i = 0; i < 16; i++) begin
            wexp[i] = d[511 - 32*i -: 32];
        end
        for (int i = 16; i < 64; i++) begin
            wexp[i] = (rotr(wexp[i-2], 17) ^ rotr(wexp[i-2], 19) ^ (wexp[i-2] >> 10))
                    + wexp[i-7]
                    + (rotr(wexp[i-15], 7) ^ rotr(wexp[i-15], 18) ^ (wexp[i-15] >> 3))
                    + wexp[i-16];
        end
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) begin
            r[32*i +: 32] = $urandom;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_blk_ready"}, blk_ready, 1);
        chk({tag, "_ld_state"}, ld_state, 0);
        chk({tag, "_ld_iv"}, ld_iv, 0);
        chk({tag, "_round_en"}, round_en, 0);
        chk({tag, "_k_addr"}, k_addr, 0);
        chk({tag, "_w_t"}, w_t, 0);
        chk({tag, "_final_add"}, final_add, 0);
        chk({tag, "_digest_valid"}, digest_valid, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_blk_ready"}, blk_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ld_state"}, ld_state, 0);
        chk({tag, "_round_en"}, round_en, 0);
        chk({tag, "_final_add"}, final_add, 0);
        chk({tag, "_digest_valid"}, digest_valid, 0);
    endtask

    task automatic do_abort();
        digest_ready = 1'b0;
        abort = 1'b1;
        #1;
        chk("abort_cyc_final_add", final_add, 0);
        chk("abort_cyc_digest_valid", digest_valid, 0);
        tick();
        abort = 1'b0;
        check_idle("after_abort");
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("post_abort");
        end
        $display("block %0d: aborted", blk_no);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        check_idle("after_rst");
        $display("block %0d: reset mid-operation", blk_no);
    endtask

    // abort_at: round index, ROUNDS = FINAL cycle, ROUNDS+1 = DONE cycle, -1 = none.
    task automatic run_block(input logic [511:0] data, input logic first, input int abort_at,
                             input int rst_at, input int hold, input bit is_abc);
        blk_no++;
        build_w(data);
        chk("accept_ready", blk_ready, 1);
        blk_valid = 1'b1;
        blk_data  = data;
        blk_first = first;
        abort     = 1'($urandom_range(0, 1));
        tick();
        blk_valid = 1'b0;
        abort     = 1'b0;
        blk_data  = rand_blk();
        blk_first = ~first;

        chk("load_ld_state", ld_state, 1);
        chk("load_ld_iv", ld_iv, first);
        chk("load_blk_ready", blk_ready, 0);
        chk("load_round_en", round_en, 0);
        chk("load_busy", busy, 1);
        tick();

        for (int t = 0; t < ROUNDS; t++) begin
            digest_ready = 1'($urandom_range(0, 1));
            chk("round_en", round_en, 1);
            chk("k_addr", k_addr, 64'(t));
            chk("w_t", w_t, wexp[t]);
            chk("round_blk_ready", blk_ready, 0);
            chk("round_ld_state", ld_state, 0);
            if (is_abc && t == 0)  chk("abc_w0", w_t, 64'h61626380);
            if (is_abc && t == 15) chk("abc_w15", w_t, 64'h18);
            if (is_abc && t == 16) chk("abc_w16", w_t, 64'h61626380);
            if (is_abc && t == 17) chk("abc_w17", w_t, 64'h000F0000);
            if (t == abort_at) begin
                do_abort();
                return;
            end
            if (t == rst_at) begin
                digest_ready = 1'b0;
                do_reset();
                return;
            end
            tick();
        end
        digest_ready = 1'b0;

        chk("final_round_en", round_en, 0);
        if (abort_at == ROUNDS) begin
            do_abort();
            return;
        end
        chk("final_add", final_add, 1);
        tick();

        chk("done_final_add", final_add, 0);
        if (abort_at == ROUNDS + 1) begin
            do_abort();
            return;
        end
        for (int h = 0; h < hold; h++) begin
            blk_valid = 1'b1;
            blk_data  = rand_blk();
            chk("hold_digest_valid", digest_valid, 1);
            chk("hold_blk_ready", blk_ready, 0);
            chk("hold_ld_state", ld_state, 0);
            tick();
        end
        blk_valid    = 1'b0;
        digest_ready = 1'b1;
        chk("hs_digest_valid", digest_valid, 1);
        tick();
        digest_ready = 1'b0;
        check_idle("after_hs");
        $display("block %0d: first=%0b digest delivered after hold %0d", blk_no, first, hold);
    endtask

    initial begin
        logic [511:0] abc;
        abc          = {32'h61626380, 448'h0, 32'h00000018};
        rst_n        = 1'b0;
        blk_valid    = 1'b0;
        blk_data     = '0;
        blk_first    = 1'b0;
        abort        = 1'b0;
        digest_ready = 1'b0;
        #2 mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_idle("idle");

        // Abort while idle is ignored.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("idle_abort");

        run_block(abc, 1'b1, -1, -1, 0, 1'b1);
        run_block(rand_blk(), 1'b1, -1, -1, 20, 1'b0);
        run_block(rand_blk(), 1'b0, -1, -1, 0, 1'b0);
        run_block(rand_blk(), 1'b1, 30, -1, 0, 1'b0);
        run_block(rand_blk(), 1'b0, -1, 40, 0, 1'b0);
        run_block(rand_blk(), 1'b1, ROUNDS, -1, 0, 1'b0);
        run_block(rand_blk(), 1'b0, ROUNDS + 1, -1, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_block(rand_blk(), 1'($urandom_range(0, 1)), -1, -1,
                      int'($urandom_range(0, 5)), 1'b0);
        end

        tick();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
